// File: rtl/dpwm_pkg.sv
// dpwm_pkg: shared constants and helpers for the multi-channel DPWM.
// Saturating duty arithmetic, select width and dead-time counter width.
package dpwm_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DT_W      = 8;

  function automatic int period_clks(int width, int presc);
    return presc * (1 << width);
  endfunction

  function automatic int sel_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] sat_add(
    logic [31:0] a,
    logic [31:0] s,
    logic [31:0] m
  );
    logic [32:0] t;
    t = {1'b0, a} + {1'b0, s};
    return (t > {1'b0, m}) ? m : t[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(
    logic [31:0] a,
    logic [31:0] s
  );
    return (a < s) ? 32'd0 : a - s;
  endfunction

endpackage

// File: rtl/dpwm_multicanal_canal.sv
// dpwm_canal: one PWM channel - shadow/active duty, compare, dead-time.
// Ports: clk, rst_n, cnt, wrap, en, inc, dec -> pwm, pwm_n, shadow.
// Macro DPWM_DEADTIME_EN adds rising-edge dead-time on pwm/pwm_n.
module dpwm_canal
  import dpwm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP      = 16,
  parameter int DUTY_RST  = 0,
  parameter int DEAD_TIME = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cnt,
  input  logic             wrap,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  output logic             pwm,
  output logic             pwm_n,
  output logic [WIDTH-1:0] shadow
);

  localparam logic [31:0] DMAX =
    (32'd1 << WIDTH) - 32'd1;
  localparam logic [WIDTH-1:0] D_RST =
    WIDTH'(DUTY_RST);

  logic [WIDTH-1:0] active;
  logic             cmp_h;
  logic             cmp_l;

  assign cmp_h = en && (cnt < active);
  assign cmp_l = en && !(cnt < active);

  // active picks up the pre-write shadow
  // when a write lands on the wrap clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= D_RST;
      active <= D_RST;
    end else begin
      if (inc)
        shadow <= WIDTH'(sat_add(
          32'(shadow), 32'(STEP), DMAX));
      else if (dec)
        shadow <= WIDTH'(sat_sub(
          32'(shadow), 32'(STEP)));
      if (wrap)
        active <= shadow;
    end
  end

`ifdef DPWM_DEADTIME_EN
  logic            raw_h;
  logic            raw_l;
  logic [DT_W-1:0] dt;

  // any change of the raw pair reloads dt;
  // outputs stay low until dt drains, so a
  // pulse no longer than DEAD_TIME vanishes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_h <= 1'b0;
      raw_l <= 1'b0;
      dt    <= '0;
    end else begin
      raw_h <= cmp_h;
      raw_l <= cmp_l;
      if (cmp_h != raw_h || cmp_l != raw_l)
        dt <= DT_W'(DEAD_TIME);
      else if (dt != '0)
        dt <= dt - DT_W'(1);
    end
  end

  assign pwm   = raw_h && (dt == '0);
  assign pwm_n = raw_l && (dt == '0);
`else
  logic unused_dt;
  assign unused_dt = ^DT_W'(DEAD_TIME);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm   <= 1'b0;
      pwm_n <= 1'b0;
    end else begin
      pwm   <= cmp_h;
      pwm_n <= cmp_l;
    end
  end
`endif

endmodule

// File: rtl/dpwm_multicanal.sv
// dpwm_multicanal: N_CH PWM channels on one shared counter.
// In: CLK_FPGA_BOARD, reinicio_n, boton_aumentar, boton_disminuir,
// seleccion_canal, habilitar. Out: pwm_out, pwm_out_n, duty_sel,
// inicio_ciclo. Optional macro: DPWM_DEADTIME_EN.
module dpwm_multicanal
  import dpwm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N_CH      = 2,
  parameter int PRESC     = 1,
  parameter int STEP      = 16,
  parameter int DUTY_RST  = 0,
  parameter int DEAD_TIME = 4
) (
  input  logic                     CLK_FPGA_BOARD,
  input  logic                     reinicio_n,
  input  logic                     boton_aumentar,
  input  logic                     boton_disminuir,
  input  logic [sel_w(N_CH)-1:0]   seleccion_canal,
  input  logic                     habilitar,
  output logic [N_CH-1:0]          pwm_out,
  output logic [N_CH-1:0]          pwm_out_n,
  output logic [WIDTH-1:0]         duty_sel,
  output logic                     inicio_ciclo
);

  localparam int SW = sel_w(N_CH);
  localparam int PW =
    (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [SW:0] NCH_V = (SW+1)'(N_CH);

  logic clk;
  assign clk = CLK_FPGA_BOARD;

  // async assert, sync release
  logic [1:0] rst_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reinicio_n) begin
    if (!reinicio_n)
      rst_q <= 2'b00;
    else
      rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_n = rst_q[1];

  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] cnt;
  logic             tick;
  logic             wrap;

  assign tick = (presc == PW'(PRESC - 1));
  assign wrap = tick && (cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc        <= '0;
      cnt          <= '0;
      inicio_ciclo <= 1'b0;
    end else begin
      presc        <= tick ? '0 : presc + PW'(1);
      if (tick)
        cnt <= cnt + WIDTH'(1);
      inicio_ciclo <= wrap;
    end
  end

  logic [2:0] up_s;
  logic [2:0] dn_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_s <= '0;
      dn_s <= '0;
    end else begin
      up_s <= {up_s[1:0], boton_aumentar};
      dn_s <= {dn_s[1:0], boton_disminuir};
    end
  end

  logic rise_up;
  logic rise_dn;
  logic sel_ok;
  logic inc_ev;
  logic dec_ev;

  assign rise_up = up_s[1] & ~up_s[2];
  assign rise_dn = dn_s[1] & ~dn_s[2];
  assign sel_ok  = {1'b0, seleccion_canal} < NCH_V;
  assign inc_ev  = rise_up & ~rise_dn & sel_ok;
  assign dec_ev  = rise_dn & ~rise_up & sel_ok;

  logic [WIDTH-1:0] shadow [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic hit;
    assign hit = (seleccion_canal == SW'(g));

    dpwm_canal #(
      .WIDTH     (WIDTH),
      .STEP      (STEP),
      .DUTY_RST  (DUTY_RST),
      .DEAD_TIME (DEAD_TIME)
    ) u_canal (
      .clk    (clk),
      .rst_n  (rst_n),
      .cnt    (cnt),
      .wrap   (wrap),
      .en     (habilitar),
      .inc    (inc_ev & hit),
      .dec    (dec_ev & hit),
      .pwm    (pwm_out[g]),
      .pwm_n  (pwm_out_n[g]),
      .shadow (shadow[g])
    );
  end

  always_comb begin
    duty_sel = '0;
    for (int i = 0; i < N_CH; i++)
      if (sel_ok && seleccion_canal == SW'(i))
        duty_sel = shadow[i];
  end

endmodule

// File: doc/dpwm_multicanal.md
Name: dpwm_multicanal

Overview:
- Parametrised multi-channel digital PWM generator; successor to the single-channel button-driven DPWM.
- Shared free-running counter, one shadowed duty register per channel, button-driven duty adjust of a selected channel, optional dead-time complementary outputs for the full-bridge stage.
- Sits between the board button/switch inputs and the gate-drive pins.
- Exports the selected channel's duty to the 7-segment display driver.

Parameters:
- WIDTH, 8: counter and duty width in bits; PWM period = PRESC * 2**WIDTH clocks.
- N_CH, 2: number of PWM channels (1..8).
- PRESC, 1: counter advances once every PRESC clocks (1..65535).
- STEP, 16: duty increment/decrement per button press.
- DUTY_RST, 0: reset duty of every channel.
- DEAD_TIME, 4: dead-time in clocks (used only with the optional feature; 0..255).

Ports:
- CLK_FPGA_BOARD  in  1  system clock.
- reinicio_n  in  1  asynchronous active-low reset.
- boton_aumentar  in  1  debounced increase button, async to clock.
- boton_disminuir  in  1  debounced decrease button, async to clock.
- seleccion_canal  in  max(1,$clog2(N_CH))  channel the buttons act on.
- habilitar  in  1  output enable; low forces all gate outputs low.
- pwm_out  out  N_CH  high-side PWM outputs.
- pwm_out_n  out  N_CH  low-side/complementary outputs.
- duty_sel  out  WIDTH  shadow duty of the selected channel, for the display.
- inicio_ciclo  out  1  one-clock pulse when the counter wraps to 0.

Behaviour:
- Reset (async assert, sync deassert internally): counter=0, prescaler=0, all shadow and active duties=DUTY_RST, synchronisers=0, pwm_out=0, pwm_out_n=0, inicio_ciclo=0, duty_sel=DUTY_RST.
- Prescaler counts 0..PRESC-1. Main counter cnt increments when the prescaler is PRESC-1. Wraps 2**WIDTH-1 -> 0.
- inicio_ciclo is asserted the clock cnt becomes 0.
- Buttons: 2-FF synchroniser each, then rising-edge detect.
- Shadow duty changes 3 clocks after the button input rises.
- Increase: shadow[sel] = min(shadow+STEP, 2**WIDTH-1); saturates, never wraps.
- Decrease: shadow[sel] = max(shadow-STEP, 0); saturates.
- Both edges in the same clock: no change.
- seleccion_canal >= N_CH: edges ignored and duty_sel=0.
- Shadow-to-active copy happens in the same clock cnt wraps to 0. This gives glitch-free duty updates.
- A shadow write in the same clock as a wrap: the new value goes to shadow; active gets the pre-write value.
- Compare: pwm_out[ch] registered = habilitar && (cnt < active[ch]); one clock latency from cnt.
- duty=0: output constant low.
- duty=2**WIDTH-1: low for exactly one count per period; 100% is not reachable by design.
- habilitar low: pwm_out and pwm_out_n go low on the next clock. Counter keeps running.
- habilitar rising: outputs resume from the current counter value; no period restart.
- Reset mid-period: outputs low immediately (async).
- duty_sel: combinational mux of shadow[seleccion_canal].

Optional Feature:
- Macro DPWM_DEADTIME_EN.
- Defined: per channel, pwm_out_n is the complement of the compare result.
  - Each rising edge of pwm_out and pwm_out_n is delayed by DEAD_TIME clocks via a per-channel down-counter; falling edges are immediate.
  - Both outputs are never high in the same clock.
  - A pulse shorter than DEAD_TIME is suppressed entirely.
  - Dead-time counters reset to 0.
- Undefined: pwm_out_n = registered ~compare && habilitar, same clock as pwm_out, no dead-time; DEAD_TIME is ignored.

Decomposition:
- Package dpwm_pkg holds:
  - Counter width/period constants.
  - Saturating add/sub functions.
  - Channel-select width function.
  - Dead-time counter width constant (8 bits).
- Sub-module dpwm_canal (one per channel, generate loop) holds:
  - Shadow/active duty registers.
  - Compare register.
  - Dead-time logic.
- Top module holds prescaler, counter, synchronisers, edge detect and select decode.

Test Plan (WIDTH=8, N_CH=2, PRESC=1, STEP=16, DEAD_TIME=4, DUTY_RST=0):
- Reset then 20 aumentar presses on ch0 -> duty_sel steps 16, 32, ... saturates at 255. pwm_out[0] high 255 of 256 clocks. ch1 stays low.
- Set ch1 shadow=64 mid-period -> pwm_out[1] unchanged until inicio_ciclo, then high exactly 64 clocks per 256-clock period.
- aumentar and disminuir rising in the same clock -> duty_sel unchanged. disminuir at duty 0 -> stays 0, no wrap to 240.
- habilitar low for 300 clocks with duty=128 -> pwm_out=pwm_out_n=0 from the next clock. On re-enable, phase is aligned to inicio_ciclo timing (counter not restarted).
- With DPWM_DEADTIME_EN, duty=128 -> pwm_out rises 4 clocks after the compare goes high; both outputs low for 4 clocks at each transition. With duty=2 the pulse is suppressed.
- reinicio_n pulled low mid-period while outputs are high -> all outputs 0 asynchronously. After release, duties=0 and the counter restarts from 0.
